// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier output stage and product_accumulator.
// "slave" is the accumulator's view; "master" is the upstream/downstream side.
interface product_accumulator_if #(
    parameter int PW    = 8,
    parameter int ACC_W = 10
);
    logic [PW-1:0]    P;
    logic             p_valid;
    logic             p_ready;
    logic             clr;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;
    logic             ovf;
    logic [7:0]       beat_cnt;

    modport master (
        output P, p_valid, clr, sum_ready,
        input  p_ready, sum, sum_valid, ovf, beat_cnt
    );

    modport slave (
        input  P, p_valid, clr, sum_ready,
        output p_ready, sum, sum_valid, ovf, beat_cnt
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums N consecutive unsigned products into one frame result and holds it
// on a valid/ready output until the consumer takes it.
module product_accumulator #(
    parameter int PW    = 8,
    parameter int N     = 4,
    parameter int ACC_W = 10
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic             carry;
    logic [7:0]       beat_cnt;
    logic [ACC_W-1:0] sum_r;
    logic             ovf_r;
    logic             sum_valid_r;

    logic             p_ready;
    logic             accept;
    logic             last_beat;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   add;
    logic             carry_next;

    always_comb begin
        p_ready    = !rst && (state != HOLD) && !bus.clr;
        accept     = bus.p_valid && p_ready;
        last_beat  = (beat_cnt == 8'(N - 1));
        // First beat of a frame loads P rather than adding to stale acc.
        base       = (state == IDLE) ? '0 : acc;
        add        = {1'b0, base} + (ACC_W + 1)'(bus.P);
        carry_next = (state != IDLE) && (carry || add[ACC_W]);

        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept)
                    state_next = last_beat ? HOLD : ACCUM;
                else if (bus.clr)
                    state_next = IDLE;
            end
            HOLD: begin
                if (sum_valid_r && bus.sum_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            carry       <= 1'b0;
            beat_cnt    <= '0;
            sum_r       <= '0;
            ovf_r       <= 1'b0;
            sum_valid_r <= 1'b0;
        end else begin
            if (state != HOLD && bus.clr) begin
                acc      <= '0;
                carry    <= 1'b0;
                beat_cnt <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    sum_r       <= add[ACC_W-1:0];
                    ovf_r       <= carry_next;
                    sum_valid_r <= 1'b1;
                    acc         <= '0;
                    carry       <= 1'b0;
                    beat_cnt    <= '0;
                end else begin
                    acc      <= add[ACC_W-1:0];
                    carry    <= carry_next;
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (state == HOLD && sum_valid_r && bus.sum_ready)
                sum_valid_r <= 1'b0;
        end
    end

    assign bus.p_ready   = p_ready;
    assign bus.sum       = sum_r;
    assign bus.ovf       = ovf_r;
    assign bus.sum_valid = sum_valid_r;
    assign bus.beat_cnt  = beat_cnt;
endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboarded bench for product_accumulator across three configurations:
// A (N=4, ACC_W=10), B (N=4, ACC_W=9) and C (N=1, ACC_W=10).
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    product_accumulator_if #(.PW(8), .ACC_W(10)) a_if ();
    product_accumulator_if #(.PW(8), .ACC_W(9))  b_if ();
    product_accumulator_if #(.PW(8), .ACC_W(10)) c_if ();

    product_accumulator #(.PW(8), .N(4), .ACC_W(10)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    product_accumulator #(.PW(8), .N(4), .ACC_W(9))  dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    product_accumulator #(.PW(8), .N(1), .ACC_W(10)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

    typedef struct {
        logic [9:0] s;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.P = '0; a_if.p_valid = 1'b0; a_if.clr = 1'b0; a_if.sum_ready = 1'b1;
        b_if.P = '0; b_if.p_valid = 1'b0; b_if.clr = 1'b0; b_if.sum_ready = 1'b1;
        c_if.P = '0; c_if.p_valid = 1'b0; c_if.clr = 1'b0; c_if.sum_ready = 1'b1;
        #2;
        vectors++;
        if (a_if.p_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p_ready: got %0d want 0", a_if.p_ready); end
        vectors++;
        if (a_if.sum_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sum_valid: got %0d want 0", a_if.sum_valid); end
        vectors++;
        if (a_if.sum !== 10'd0) begin miscompares++; $display("FAIL reset_sum: got %0d want 0", a_if.sum); end
        vectors++;
        if (a_if.beat_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_beat_cnt: got %0d want 0", a_if.beat_cnt); end
        vectors++;
        if (a_if.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %0d want 0", a_if.ovf); end
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (a_if.p_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_p_ready: got %0d want 1", a_if.p_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] pv [4] = '{8'd24, 8'd16, 8'd64, 8'd27};
        logic [7:0] bc [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
        exp_q.push_back('{10'd131, 1'b0});
        for (int unsigned i = 0; i < 4; i++) begin
            a_if.P = pv[i]; a_if.p_valid = 1'b1; a_if.sum_ready = 1'b1;
            #1;
            vectors++;
            if (a_if.p_ready !== 1'b1) begin miscompares++; $display("FAIL basic_p_ready[%0d]: got %0d want 1", i, a_if.p_ready); end
            step();
            vectors++;
            if (a_if.beat_cnt !== bc[i]) begin miscompares++; $display("FAIL basic_beat_cnt[%0d]: got %0d want %0d", i, a_if.beat_cnt, bc[i]); end
            vectors++;
            if (a_if.sum_valid !== (i == 3)) begin miscompares++; $display("FAIL basic_sum_valid[%0d]: got %0d want %0d", i, a_if.sum_valid, (i == 3)); end
        end
        a_if.p_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (a_if.sum !== e.s) begin miscompares++; $display("FAIL basic_sum: got %0d want %0d", a_if.sum, e.s); end
        vectors++;
        if (a_if.ovf !== e.o) begin miscompares++; $display("FAIL basic_ovf: got %0d want %0d", a_if.ovf, e.o); end
        vectors++;
        if (a_if.p_ready !== 1'b0) begin miscompares++; $display("FAIL basic_hold_p_ready: got %0d want 0", a_if.p_ready); end
        step();
        vectors++;
        if (a_if.sum_valid !== 1'b0) begin miscompares++; $display("FAIL basic_sum_valid_drop: got %0d want 0", a_if.sum_valid); end
        vectors++;
        if (a_if.p_ready !== 1'b1) begin miscompares++; $display("FAIL basic_p_ready_back: got %0d want 1", a_if.p_ready); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pv [4] = '{8'd72, 8'd9, 8'd8, 8'd2};
        exp_q.push_back('{10'd91, 1'b0});
        a_if.sum_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            a_if.P = pv[i]; a_if.p_valid = 1'b1;
            step();
        end
        a_if.P = 8'd77;
        e = exp_q.pop_front();
        for (int unsigned k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (a_if.sum_valid !== 1'b1 || a_if.sum !== e.s || a_if.ovf !== e.o)
                begin miscompares++; $display("FAIL bp_hold[%0d]: got sum_valid=%0d sum=%0d ovf=%0d want 1/%0d/%0d", k, a_if.sum_valid, a_if.sum, a_if.ovf, e.s, e.o); end
            vectors++;
            if (a_if.p_ready !== 1'b0 || a_if.beat_cnt !== 8'd0)
                begin miscompares++; $display("FAIL bp_no_accept[%0d]: got p_ready=%0d beat_cnt=%0d want 0/0", k, a_if.p_ready, a_if.beat_cnt); end
            step();
        end
        a_if.sum_ready = 1'b1;
        step();
        vectors++;
        if (a_if.sum_valid !== 1'b0 || a_if.beat_cnt !== 8'd0)
            begin miscompares++; $display("FAIL bp_handshake: got sum_valid=%0d beat_cnt=%0d want 0/0", a_if.sum_valid, a_if.beat_cnt); end
        exp_q.push_back('{10'd80, 1'b0});
        step();
        vectors++;
        if (a_if.beat_cnt !== 8'd1) begin miscompares++; $display("FAIL bp_held_beat: got %0d want 1", a_if.beat_cnt); end
        for (int unsigned i = 0; i < 3; i++) begin
            a_if.P = 8'd1;
            step();
        end
        a_if.p_valid = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (a_if.sum_valid !== 1'b1 || a_if.sum !== e.s)
            begin miscompares++; $display("FAIL bp_next_frame: got sum_valid=%0d sum=%0d want 1/%0d", a_if.sum_valid, a_if.sum, e.s); end
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] fv [2] = '{8'd225, 8'd1};
        exp_q.push_back('{10'd388, 1'b1});
        exp_q.push_back('{10'd4, 1'b0});
        for (int unsigned f = 0; f < 2; f++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                b_if.P = fv[f]; b_if.p_valid = 1'b1;
                step();
            end
            b_if.p_valid = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (b_if.sum_valid !== 1'b1 || b_if.sum !== e.s[8:0])
                begin miscompares++; $display("FAIL ovf_sum[%0d]: got sum_valid=%0d sum=%0d want 1/%0d", f, b_if.sum_valid, b_if.sum, e.s); end
            vectors++;
            if (b_if.ovf !== e.o) begin miscompares++; $display("FAIL ovf_flag[%0d]: got %0d want %0d", f, b_if.ovf, e.o); end
            step();
        end
    endtask

    task automatic test_gaps_abort();
        logic [7:0] pv [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        a_if.P = 8'd10; a_if.p_valid = 1'b1;
        step();
        a_if.p_valid = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (a_if.beat_cnt !== 8'd1) begin miscompares++; $display("FAIL gap_beat_cnt[%0d]: got %0d want 1", k, a_if.beat_cnt); end
        end
        a_if.P = 8'd20; a_if.p_valid = 1'b1;
        step();
        vectors++;
        if (a_if.beat_cnt !== 8'd2) begin miscompares++; $display("FAIL gap_resume: got %0d want 2", a_if.beat_cnt); end
        a_if.P = 8'd99; a_if.clr = 1'b1;
        #1;
        vectors++;
        if (a_if.p_ready !== 1'b0) begin miscompares++; $display("FAIL clr_p_ready: got %0d want 0", a_if.p_ready); end
        step();
        a_if.clr = 1'b0; a_if.p_valid = 1'b0;
        vectors++;
        if (a_if.beat_cnt !== 8'd0 || a_if.sum_valid !== 1'b0)
            begin miscompares++; $display("FAIL clr_cleared: got beat_cnt=%0d sum_valid=%0d want 0/0", a_if.beat_cnt, a_if.sum_valid); end
        exp_q.push_back('{10'd10, 1'b0});
        a_if.sum_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            a_if.P = pv[i]; a_if.p_valid = 1'b1;
            step();
        end
        a_if.p_valid = 1'b0;
        a_if.clr = 1'b1;
        step();
        e = exp_q.pop_front();
        vectors++;
        if (a_if.sum_valid !== 1'b1 || a_if.sum !== e.s || a_if.ovf !== e.o)
            begin miscompares++; $display("FAIL clr_in_hold: got sum_valid=%0d sum=%0d ovf=%0d want 1/%0d/%0d", a_if.sum_valid, a_if.sum, a_if.ovf, e.s, e.o); end
        a_if.clr = 1'b0; a_if.sum_ready = 1'b1;
        step();
        vectors++;
        if (a_if.sum_valid !== 1'b0) begin miscompares++; $display("FAIL clr_hold_release: got %0d want 0", a_if.sum_valid); end
    endtask

    task automatic test_reset_mid();
        a_if.P = 8'd50; a_if.p_valid = 1'b1;
        step();
        a_if.P = 8'd60;
        step();
        a_if.p_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (a_if.beat_cnt !== 8'd0 || a_if.sum !== 10'd0 || a_if.sum_valid !== 1'b0)
            begin miscompares++; $display("FAIL async_reset: got beat_cnt=%0d sum=%0d sum_valid=%0d want 0/0/0", a_if.beat_cnt, a_if.sum, a_if.sum_valid); end
        vectors++;
        if (a_if.p_ready !== 1'b0) begin miscompares++; $display("FAIL async_reset_p_ready: got %0d want 0", a_if.p_ready); end
        rst = 1'b0;
        step();
        exp_q.push_back('{10'd20, 1'b0});
        for (int unsigned i = 0; i < 4; i++) begin
            a_if.P = 8'd5; a_if.p_valid = 1'b1;
            step();
        end
        a_if.p_valid = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (a_if.sum_valid !== 1'b1 || a_if.sum !== e.s)
            begin miscompares++; $display("FAIL post_reset_frame: got sum_valid=%0d sum=%0d want 1/%0d", a_if.sum_valid, a_if.sum, e.s); end
        step();
    endtask

    task automatic test_back_to_back_n1();
        c_if.sum_ready = 1'b1;
        exp_q.push_back('{10'd225, 1'b0});
        exp_q.push_back('{10'd3, 1'b0});
        c_if.P = 8'd225; c_if.p_valid = 1'b1;
        step();
        c_if.P = 8'd3;
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (c_if.sum_valid !== 1'b1 || c_if.sum !== e.s)
            begin miscompares++; $display("FAIL n1_first: got sum_valid=%0d sum=%0d want 1/%0d", c_if.sum_valid, c_if.sum, e.s); end
        vectors++;
        if (c_if.p_ready !== 1'b0 || c_if.beat_cnt !== 8'd0)
            begin miscompares++; $display("FAIL n1_bubble: got p_ready=%0d beat_cnt=%0d want 0/0", c_if.p_ready, c_if.beat_cnt); end
        step();
        vectors++;
        if (c_if.sum_valid !== 1'b0 || c_if.p_ready !== 1'b1)
            begin miscompares++; $display("FAIL n1_gap: got sum_valid=%0d p_ready=%0d want 0/1", c_if.sum_valid, c_if.p_ready); end
        step();
        c_if.p_valid = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (c_if.sum_valid !== 1'b1 || c_if.sum !== e.s)
            begin miscompares++; $display("FAIL n1_second: got sum_valid=%0d sum=%0d want 1/%0d", c_if.sum_valid, c_if.sum, e.s); end
        step();
        vectors++;
        if (c_if.sum_valid !== 1'b0) begin miscompares++; $display("FAIL n1_drain: got %0d want 0", c_if.sum_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_gaps_abort();
        test_reset_mid();
        test_back_to_back_n1();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier.
- Takes its 8-bit product P through a valid/ready handshake and sums N consecutive products into one frame result.
- Presents the result on a held output handshake with backpressure.
- Forms the accumulate half of the team's multiply-accumulate datapath. Operands and products are unsigned.

Parameters:
- PW, 8, product input width (matches multiplier P width).
- N, 4, products per frame; legal range 1..255.
- ACC_W, 10, accumulator and result width; must be >= PW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- P  input  PW  product from multiplier.
- p_valid  input  1  P is valid this cycle.
- p_ready  output  1  block can accept P this cycle.
- clr  input  1  synchronous abort of the partial frame.
- sum  output  ACC_W  frame result.
- sum_valid  output  1  sum and ovf are valid.
- sum_ready  input  1  downstream accepts sum.
- ovf  output  1  frame overflowed ACC_W, qualified by sum_valid.
- beat_cnt  output  8  products accepted in the current frame.

Behaviour:
- Reset (async, rst=1): state=IDLE; acc, beat_cnt, sum, ovf, sum_valid all 0; p_ready=0 while rst is high.
- States are IDLE (no beats yet), ACCUM (1..N-1 beats taken) and HOLD (result waiting).
- p_ready = (state != HOLD) && !clr. This is combinational from state and clr only, never from p_valid.
- Accept occurs when p_valid && p_ready at a rising clk.
  - First beat of a frame: acc <= zero-extended P.
  - Later beats: acc <= acc + P, taken modulo 2^ACC_W.
  - beat_cnt increments by 1.
  - A frame-local carry flag is set if any addition carries out of bit ACC_W-1.
- On the accept that makes beat_cnt reach N:
  - sum <= final acc value, including this beat.
  - ovf <= the carry flag, including this beat.
  - sum_valid <= 1, state <= HOLD.
  - acc, beat_cnt and the carry flag are cleared.
- Latency: sum_valid rises 1 cycle after the Nth accept edge.
- Sustained throughput is N beats per N+1 cycles minimum: one bubble cycle in HOLD, assuming sum_ready is already high.
- HOLD:
  - sum, ovf and sum_valid stay stable until sum_valid && sum_ready.
  - On that handshake edge: sum_valid <= 0 and state <= IDLE. sum and ovf keep their values but are don't-care.
  - p_ready is 0 throughout HOLD, so no beat is accepted in the handshake cycle.
- clr=1 in IDLE/ACCUM: next edge sets acc=0, beat_cnt=0, carry=0, state=IDLE. No result is produced. A p_valid beat in the same cycle is not accepted (p_ready=0); the upstream must hold it.
- clr=1 in HOLD: ignored; the pending result is preserved.
- N=1: every accept goes straight from IDLE to HOLD with sum=P.
- p_valid low mid-frame: acc holds and the frame resumes on the next accept. There is no timeout.
- rst mid-frame or in HOLD: the partial frame and any pending result are discarded immediately (async).
- P has no X-propagation requirement when p_valid=0.

Test Plan:
- Basic frame (N=4, ACC_W=10): P=24,16,64,27 with p_valid continuous, sum_ready=1 -> sum_valid pulses 1 cycle after the 4th accept; sum=131, ovf=0; p_ready low for exactly 1 cycle; beat_cnt sequence 1,2,3,0.
- Backpressure: after frame P=72,9,8,2, hold sum_ready=0 for 5 cycles while p_valid=1 -> sum=91 stable; sum_valid=1 and p_ready=0 for all 5 cycles; no beat accepted. Raise sum_ready -> the next frame starts with the held P.
- Overflow (ACC_W=9, N=4): P=225 four times -> sum=388 (900 mod 512), ovf=1. The next frame 1,1,1,1 gives sum=4, ovf=0.
- Gaps and abort: P=10, p_valid low 3 cycles, P=20, then clr=1 with p_valid=1 and P=99 -> p_ready=0 that cycle; beat_cnt=0 after. Following frame 1,2,3,4 gives sum=10. clr asserted in HOLD leaves sum unchanged.
- Reset mid-operation: accept P=50,60, assert rst asynchronously between edges -> beat_cnt, sum, sum_valid read 0 immediately. After release, frame 5,5,5,5 gives sum=20.
- N=1 config: P=225 then P=3 back-to-back with sum_ready=1 -> two results, 225 then 3, each 1 cycle after its accept, with one bubble between them.
